// File: rtl/generatore_sincronismi.sv
// 1280x1024@60 raster timing: X/Y scan counters, syncs, ACTIVE and strobes.
// Optional FRAME_CNT output enabled by GENERATORE_CONTAFRAME_EN.
module generatore_sincronismi #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CE,
  output logic [10:0] X_CONTROLLO,
  output logic [10:0] Y_CONTROLLO,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        ACTIVE,
  output logic        LINE_START,
  output logic        FRAME_START
`ifdef GENERATORE_CONTAFRAME_EN
  ,
  output logic [7:0]  FRAME_CNT
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_A_END  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_FP_END = 11'(H_ACTIVE + H_FP - 1);
  localparam logic [10:0] H_SY_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_A_END  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_FP_END = 11'(V_ACTIVE + V_FP - 1);
  localparam logic [10:0] V_SY_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_range_err
    $error("generatore_sincronismi: H_TOTAL/V_TOTAL exceed 2048");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
  begin : g_zero_err
    $error("generatore_sincronismi: every timing segment must be >= 1");
  end

  typedef enum logic [3:0] {
    ST_ATTIVO = 4'b0001,
    ST_FP     = 4'b0010,
    ST_SYNC   = 4'b0100,
    ST_BP     = 4'b1000
  } fase_t;

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  fase_t       h_st_q, h_st_d;
  fase_t       v_st_q, v_st_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic        line_q, line_d;
  logic        frame_q, frame_d;
  logic        h_wrap;
  logic        v_wrap;
`ifdef GENERATORE_CONTAFRAME_EN
  logic [7:0]  fcnt_q, fcnt_d;
`endif

  assign h_wrap = CE && (x_q == H_LAST);
  assign v_wrap = h_wrap && (y_q == V_LAST);

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    h_st_d = h_st_q;
    v_st_d = v_st_q;
    if (CE) begin
      x_d = h_wrap ? 11'd0 : x_q + 11'd1;
      unique case (1'b1)
        x_q == H_A_END:  h_st_d = ST_FP;
        x_q == H_FP_END: h_st_d = ST_SYNC;
        x_q == H_SY_END: h_st_d = ST_BP;
        x_q == H_LAST:   h_st_d = ST_ATTIVO;
        default:         h_st_d = h_st_q;
      endcase
    end
    // Vertical phase only moves on line wrap, so VSYNC spans whole lines
    if (h_wrap) begin
      y_d = v_wrap ? 11'd0 : y_q + 11'd1;
      unique case (1'b1)
        y_q == V_A_END:  v_st_d = ST_FP;
        y_q == V_FP_END: v_st_d = ST_SYNC;
        y_q == V_SY_END: v_st_d = ST_BP;
        y_q == V_LAST:   v_st_d = ST_ATTIVO;
        default:         v_st_d = v_st_q;
      endcase
    end
  end

  always_comb begin
    hsync_d  = (h_st_d == ST_SYNC) ? H_POL : ~H_POL;
    vsync_d  = (v_st_d == ST_SYNC) ? V_POL : ~V_POL;
    active_d = (h_st_d == ST_ATTIVO) && (v_st_d == ST_ATTIVO);
    line_d   = (x_d == 11'd0);
    frame_d  = (x_d == 11'd0) && (y_d == 11'd0);
  end

`ifdef GENERATORE_CONTAFRAME_EN
  always_comb begin
    fcnt_d = fcnt_q;
    if (v_wrap) fcnt_d = fcnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) fcnt_q <= 8'd0;
    else          fcnt_q <= fcnt_d;
  end

  assign FRAME_CNT = fcnt_q;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q      <= 11'd0;
      y_q      <= 11'd0;
      h_st_q   <= ST_ATTIVO;
      v_st_q   <= ST_ATTIVO;
      hsync_q  <= ~H_POL;
      vsync_q  <= ~V_POL;
      active_q <= 1'b1;
      line_q   <= 1'b1;
      frame_q  <= 1'b1;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      h_st_q   <= h_st_d;
      v_st_q   <= v_st_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign X_CONTROLLO = x_q;
  assign Y_CONTROLLO = y_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign ACTIVE      = active_q;
  assign LINE_START  = line_q;
  assign FRAME_START = frame_q;

endmodule

// File: tb/tb_generatore_sincronismi.sv
// Bench: full-size instance for line-level timing, small instance for frames.
// Flags packed as {HSYNC,VSYNC,ACTIVE,LINE_START,FRAME_START}.
module tb_generatore_sincronismi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ce_b, ce_s;
  logic [10:0] xb, yb, xs, ys;
  logic        hsb, vsb, acb, lsb, fsb;
  logic        hss, vss, acs, lss, fss;
`ifdef GENERATORE_CONTAFRAME_EN
  logic [7:0]  fcb, fcs;
`endif

  generatore_sincronismi u_big (
    .CLK(clk), .RESET_N(rst_n), .CE(ce_b),
    .X_CONTROLLO(xb), .Y_CONTROLLO(yb),
    .HSYNC(hsb), .VSYNC(vsb), .ACTIVE(acb),
    .LINE_START(lsb), .FRAME_START(fsb)
`ifdef GENERATORE_CONTAFRAME_EN
    , .FRAME_CNT(fcb)
`endif
  );

  // 16x10 raster, active-low syncs
  generatore_sincronismi #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_sml (
    .CLK(clk), .RESET_N(rst_n), .CE(ce_s),
    .X_CONTROLLO(xs), .Y_CONTROLLO(ys),
    .HSYNC(hss), .VSYNC(vss), .ACTIVE(acs),
    .LINE_START(lss), .FRAME_START(fss)
`ifdef GENERATORE_CONTAFRAME_EN
    , .FRAME_CNT(fcs)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         x;
    int         y;
    logic [4:0] fl;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [26:0] pk(int x, int y, logic [4:0] f);
    return {11'(x), 11'(y), f};
  endfunction

  function automatic logic [26:0] got_b();
    return {xb, yb, hsb, vsb, acb, lsb, fsb};
  endfunction

  function automatic logic [26:0] got_s();
    return {xs, ys, hss, vss, acs, lss, fss};
  endfunction

  task automatic chk(string nm, logic [26:0] got, logic [26:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got x=%0d y=%0d fl=%b, want x=%0d y=%0d fl=%b",
               nm, got[26:16], got[15:5], got[4:0],
               exp[26:16], exp[15:5], exp[4:0]);
    end
  endtask

  task automatic chk_int(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic step_b(int n);
    if (n > 0) begin
      ce_b = 1'b1;
      repeat (n) @(negedge clk);
      ce_b = 1'b0;
    end
  endtask

  task automatic step_s(int n);
    if (n > 0) begin
      ce_s = 1'b1;
      repeat (n) @(negedge clk);
      ce_s = 1'b0;
    end
  endtask

  initial begin
    int cur;
    int tgt;
    int hs_n, hs_first, hs_last;
    int vs_n, vs_first, vs_last, hs2_n, act_n, ls_n, fs_n;

    tbl[0]  = '{1,    0, 5'b00100};
    tbl[1]  = '{1279, 0, 5'b00100};
    tbl[2]  = '{1280, 0, 5'b00000};
    tbl[3]  = '{1327, 0, 5'b00000};
    tbl[4]  = '{1328, 0, 5'b10000};
    tbl[5]  = '{1439, 0, 5'b10000};
    tbl[6]  = '{1440, 0, 5'b00000};
    tbl[7]  = '{1687, 0, 5'b00000};
    tbl[8]  = '{0,    1, 5'b00110};
    tbl[9]  = '{1687, 5, 5'b00000};
    tbl[10] = '{0,    6, 5'b00110};
    tbl[11] = '{500,  6, 5'b00100};

    rst_n = 1'b0;
    ce_b  = 1'b1;
    ce_s  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_big", got_b(), pk(0, 0, 5'b00111));
    ce_b = 1'b0;

    cur = 0;
    for (int i = 0; i < 12; i++) begin
      tgt = tbl[i].y * 1688 + tbl[i].x;
      step_b(tgt - cur);
      cur = tgt;
      chk($sformatf("vec%0d", i), got_b(),
          pk(tbl[i].x, tbl[i].y, tbl[i].fl));
    end

    step_b(1188);
    chk("line7_start", got_b(), pk(0, 7, 5'b00110));
    hs_n = 0;
    hs_first = -1;
    hs_last = -1;
    for (int i = 0; i < 1688; i++) begin
      if (hsb) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(xb);
        hs_last = int'(xb);
      end
      step_b(1);
    end
    chk_int("hsync_count", hs_n, 112);
    chk_int("hsync_first", hs_first, 1328);
    chk_int("hsync_last", hs_last, 1439);

    step_b(500);
    ce_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("ce_hold%0d", i), got_b(), pk(500, 8, 5'b00100));
    end

    step_b(830);
    chk("pre_reset_sync", got_b(), pk(1330, 8, 5'b10000));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_big", got_b(), pk(0, 0, 5'b00111));
    chk("async_reset_sml", got_s(), pk(0, 0, 5'b11111));
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_hold_big", got_b(), pk(0, 0, 5'b00111));

    vs_n = 0;
    vs_first = -1;
    vs_last = -1;
    hs2_n = 0;
    act_n = 0;
    ls_n = 0;
    fs_n = 0;
    for (int i = 0; i < 160; i++) begin
      if (!vss) begin
        vs_n++;
        if (vs_first < 0) vs_first = int'(ys);
        vs_last = int'(ys);
      end
      if (!hss) hs2_n++;
      if (acs) act_n++;
      if (lss) ls_n++;
      if (fss) fs_n++;
      if (i == 159) chk("sml_last_px", got_s(), pk(15, 9, 5'b11000));
      step_s(1);
    end
    chk_int("sml_vsync_count", vs_n, 32);
    chk_int("sml_vsync_first", vs_first, 7);
    chk_int("sml_vsync_last", vs_last, 8);
    chk_int("sml_hsync_count", hs2_n, 30);
    chk_int("sml_active_count", act_n, 48);
    chk_int("sml_line_starts", ls_n, 10);
    chk_int("sml_frame_starts", fs_n, 1);
    chk("sml_frame_wrap", got_s(), pk(0, 0, 5'b11111));

`ifdef GENERATORE_CONTAFRAME_EN
    chk_int("fcnt_1", int'(fcs), 1);
    step_s(254 * 160);
    chk_int("fcnt_255", int'(fcs), 255);
    step_s(160);
    chk_int("fcnt_wrap", int'(fcs), 0);
    chk("fcnt_pos", got_s(), pk(0, 0, 5'b11111));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/generatore_sincronismi.md
Name: generatore_sincronismi

Overview:
- Video timing generator for the 1280x1024@60 raster.
- Produces the pixel scan coordinates X_CONTROLLO/Y_CONTROLLO that feed every rettangolo/cornicetta hit-tester in the display path.
- Also produces HSYNC, VSYNC, ACTIVE and line/frame strobes, so shape outputs are qualified and muxed by a single timing source.

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 48, horizontal front porch (pixels)
H_SYNC, 112, horizontal sync width (pixels)
H_BP, 248, horizontal back porch (pixels)
V_ACTIVE, 1024, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BP, 38, vertical back porch (lines)
H_POL, 1, HSYNC asserted level (1 = active high)
V_POL, 1, VSYNC asserted level (1 = active high)

Ports:
CLK  input  1  pixel clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
CE  input  1  pixel clock enable; state advances only when high
X_CONTROLLO  output  11  horizontal counter, 0..H_TOTAL-1
Y_CONTROLLO  output  11  vertical counter, 0..V_TOTAL-1
HSYNC  output  1  horizontal sync, polarity per H_POL
VSYNC  output  1  vertical sync, polarity per V_POL
ACTIVE  output  1  high while X<H_ACTIVE and Y<V_ACTIVE
LINE_START  output  1  high while X==0
FRAME_START  output  1  high while X==0 and Y==0

Behaviour:
- Reset and clock: one clock, CLK. RESET_N is asynchronous and active-low. Assertion immediately forces the state below, including mid-line or mid-frame.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1688); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (1066). Both must be ≤2048; an elaboration-time check flags violations.
- Reset state: X=0, Y=0, ACTIVE=1, LINE_START=1, FRAME_START=1. HSYNC=!H_POL, VSYNC=!V_POL (deasserted).
- Every output is a registered signal, updated in the same CLK edge as the counters. No output has a combinational path from CE.
- CE=1 at a rising edge: X increments. At X==H_TOTAL-1, X wraps to 0 and Y increments. At Y==V_TOTAL-1 together with X==H_TOTAL-1, both wrap to 0.
- CE=0: all registers hold their value.
- Counters use 11-bit unsigned arithmetic. Wrap is by compare-and-clear, never by natural overflow.
- HSYNC asserted for X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1328, 1439].
- VSYNC asserted for Y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [1025, 1027], over whole lines (changes only when X wraps to 0).
- ACTIVE, LINE_START and FRAME_START are exact decodes of the registered X/Y. Each strobe is high for exactly one CE-qualified pixel.
- X/Y are not blanked outside the active area. Consumers gate hit-test results with ACTIVE.
- Line phase FSM (decoded from X, one-hot internally): ATTIVO → FP → SYNC → BP → ATTIVO. Transitions occur on the CE edges at the boundary values above. The vertical FSM has the same shape and advances only on line wrap.

Optional Feature:
- Macro: GENERATORE_CONTAFRAME_EN.
- Defined: adds output FRAME_CNT [7:0]. It resets to 0, increments on the CE edge where X and Y both wrap to 0, and wraps 255→0. It is used for sprite animation pacing.
- Undefined: port and register are absent. All other behaviour is identical.

Test Plan:
- Reset: hold RESET_N=0, then release with CE=1 → X=0,Y=0,ACTIVE=1,FRAME_START=1,HSYNC=0,VSYNC=0. After 1 edge: X=1, FRAME_START=0, LINE_START=0.
- Line wrap: run to X=1687,Y=5, one CE edge → X=0, Y=6, LINE_START=1. ACTIVE=0 at X=1280, 1 again at X=0.
- HSYNC window: over one line, HSYNC=1 for exactly 112 consecutive pixels, first at X=1328, last at X=1439. VSYNC=1 for Y=1025..1027 only (3×1688 pixels).
- Frame wrap and CE: at X=1687,Y=1065 with CE=1 → X=0,Y=0,FRAME_START=1. With CE=0 held for 10 edges at X=500, outputs are unchanged throughout.
- Async reset mid-frame: drop RESET_N at X=900,Y=700 between edges → X=0,Y=0 and HSYNC/VSYNC deasserted before the next CLK edge.
- With GENERATORE_CONTAFRAME_EN: 256 frame wraps from reset → FRAME_CNT=0, having read 255 after the 255th wrap.
